alu_arbiter: RTL and testbench

Two-requester round-robin arbiter and sequencer for the shared 8-bit combinational ALU. Accepts operation requests (op code plus two operands) over valid/ready handshakes, drives the ALU for exactly one cycle, and registers the result and flags. The result is returned over a valid/ready response channel tagged with the requester ID. It sits between the control unit and the auxiliary address/compare logic, which both issue ALU operations.

---
 rtl/alu_arbiter.sv | 106 ++++++++++
 tb/tb_alu_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer for one shared combinational ALU: two requesters, one op in flight.
// Accept -> ALU inputs registered -> flags/result captured next edge; response held until consumed.
module alu_arbiter #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [1:0]   req_valid_i,
  output logic [1:0]   req_ready_o,
  input  logic [2:0]   req_op0_i,
  input  logic [2:0]   req_op1_i,
  input  logic [n-1:0] req_a0_i,
  input  logic [n-1:0] req_a1_i,
  input  logic [n-1:0] req_b0_i,
  input  logic [n-1:0] req_b1_i,
  output logic [2:0]   alu_cntrl_o,
  output logic [n-1:0] alu_in1_o,
  output logic [n-1:0] alu_in2_o,
  input  logic [n-1:0] alu_out_i,
  input  logic         alu_V_i,
  input  logic         alu_Z_i,
  input  logic         alu_cout_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic         rsp_id_o,
  output logic [n-1:0] rsp_result_o,
  output logic         rsp_V_o,
  output logic         rsp_Z_o,
  output logic         rsp_cout_o
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state_q;
  logic           last_grant_q;
  logic [2:0]     cntrl_q;
  logic [n-1:0]   in1_q, in2_q;
  logic           rsp_valid_q, rsp_id_q, rsp_V_q, rsp_Z_q, rsp_cout_q;
  logic [n-1:0]   rsp_result_q;
  logic [1:0]     grant;
  logic           grant_id;

  // On a tie the requester not served last wins; otherwise the sole valid one.
  always_comb begin
    grant = req_valid_i;
    if (req_valid_i == 2'b11) grant = last_grant_q ? 2'b01 : 2'b10;
  end

  assign grant_id    = grant[1];
  assign req_ready_o = (state_q == IDLE) ? grant : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cntrl_q      <= 3'b111;
      in1_q        <= '0;
      in2_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_V_q      <= 1'b0;
      rsp_Z_q      <= 1'b0;
      rsp_cout_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|grant) begin
            cntrl_q      <= grant_id ? req_op1_i : req_op0_i;
            in1_q        <= grant_id ? req_a1_i  : req_a0_i;
            in2_q        <= grant_id ? req_b1_i  : req_b0_i;
            rsp_id_q     <= grant_id;
            last_grant_q <= grant_id;
            state_q      <= EXEC;
          end
        end
        EXEC: begin
          rsp_result_q <= alu_out_i;
          rsp_V_q      <= alu_V_i;
          rsp_Z_q      <= alu_Z_i;
          rsp_cout_q   <= alu_cout_i;
          rsp_valid_q  <= 1'b1;
          state_q      <= RESP;
        end
        RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_cntrl_o  = cntrl_q;
  assign alu_in1_o    = in1_q;
  assign alu_in2_o    = in2_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_id_o     = rsp_id_q;
  assign rsp_result_o = rsp_result_q;
  assign rsp_V_o      = rsp_V_q;
  assign rsp_Z_o      = rsp_Z_q;
  assign rsp_cout_o   = rsp_cout_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: ALU stub, cycle model with per-negedge compare, directed scenarios.
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req_valid, req_ready;
  logic [2:0] op0, op1;
  logic [7:0] a0, a1, b0, b1;
  logic [2:0] alu_cntrl;
  logic [7:0] alu_in1, alu_in2, alu_out;
  logic       alu_V, alu_Z, alu_cout;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_V, rsp_Z, rsp_cout;
  logic [7:0] rsp_result;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter #(.n(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op0_i(op0), .req_op1_i(op1),
    .req_a0_i(a0), .req_a1_i(a1), .req_b0_i(b0), .req_b1_i(b1),
    .alu_cntrl_o(alu_cntrl), .alu_in1_o(alu_in1), .alu_in2_o(alu_in2),
    .alu_out_i(alu_out), .alu_V_i(alu_V), .alu_Z_i(alu_Z), .alu_cout_i(alu_cout),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id),
    .rsp_result_o(rsp_result), .rsp_V_o(rsp_V), .rsp_Z_o(rsp_Z), .rsp_cout_o(rsp_cout)
  );

  // Returns {V, Z, cout, result}
  function automatic logic [10:0] alu_f(input logic [2:0] c, input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic       v;
    v = 1'b0;
    case (c)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; v = (a[7] == b[7]) && (s[7] != a[7]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; v = (a[7] != b[7]) && (s[7] != a[7]); end
      3'd2: s = {1'b0, a | b};
      3'd3: s = {1'b0, a & b};
      3'd4: s = {a, 1'b0};
      3'd5: s = {a[0], 1'b0, a[7:1]};
      3'd6: s = {1'b0, ~a};
      default: s = {1'b0, a};
    endcase
    return {v, (s[7:0] == 8'h00), s[8], s[7:0]};
  endfunction

  always_comb {alu_V, alu_Z, alu_cout, alu_out} = alu_f(alu_cntrl, alu_in1, alu_in2);

  function automatic logic [1:0] pick(input logic [1:0] v, input logic last);
    if (v == 2'b11) return last ? 2'b01 : 2'b10;
    return v;
  endfunction

  // Model: phase 0 = free, 1 = ALU computing, 2 = result waiting for consumer
  int         m_ph;
  logic       m_last, m_id, m_rv, m_V, m_Z, m_co;
  logic [2:0] m_c;
  logic [7:0] m_i1, m_i2, m_res;
  logic [1:0] m_g, m_rdy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_last = 1'b1; m_c = 3'b111; m_i1 = 8'h00; m_i2 = 8'h00;
      m_id = 1'b0; m_rv = 1'b0; m_res = 8'h00; m_V = 1'b0; m_Z = 1'b0; m_co = 1'b0;
    end else if (m_ph == 0) begin
      m_g = pick(req_valid, m_last);
      if (m_g != 2'b00) begin
        m_id = m_g[1]; m_last = m_g[1];
        m_c  = m_g[1] ? op1 : op0;
        m_i1 = m_g[1] ? a1 : a0;
        m_i2 = m_g[1] ? b1 : b0;
        m_ph = 1;
      end
    end else if (m_ph == 1) begin
      {m_V, m_Z, m_co, m_res} = alu_f(m_c, m_i1, m_i2);
      m_rv = 1'b1;
      m_ph = 2;
    end else if (rsp_ready) begin
      m_rv = 1'b0;
      m_ph = 0;
    end
  end

  always @(negedge clk) begin
    m_rdy = (m_ph == 0) ? pick(req_valid, m_last) : 2'b00;
    n_cmp++;
    if ({req_ready, alu_cntrl, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_result, rsp_V, rsp_Z, rsp_cout} !==
        {m_rdy, m_c, m_i1, m_i2, m_rv, m_id, m_res, m_V, m_Z, m_co}) begin
      n_err++;
      $display("FAIL cycle_model t=%0t got rdy=%b op=%h in1=%h in2=%h rv=%b id=%b res=%h VZC=%b%b%b expected rdy=%b op=%h in1=%h in2=%h rv=%b id=%b res=%h VZC=%b%b%b",
               $time, req_ready, alu_cntrl, alu_in1, alu_in2, rsp_valid, rsp_id, rsp_result, rsp_V, rsp_Z, rsp_cout,
               m_rdy, m_c, m_i1, m_i2, m_rv, m_id, m_res, m_V, m_Z, m_co);
    end
  end

  int         acc_log[$];
  logic [9:0] rsp_log[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (req_valid[0] && req_ready[0]) acc_log.push_back(0);
      if (req_valid[1] && req_ready[1]) acc_log.push_back(1);
      if (rsp_valid && rsp_ready) rsp_log.push_back({rsp_id, rsp_Z, rsp_result});
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int acc_at(input int i);
    return (acc_log.size() > i) ? acc_log[i] : -1;
  endfunction

  function automatic logic [31:0] rsp_at(input int i);
    return (rsp_log.size() > i) ? {22'h0, rsp_log[i]} : 32'hFFFF_FFFF;
  endfunction

  initial begin
    req_valid = 2'b00; rsp_ready = 1'b0;
    op0 = 3'd0; op1 = 3'd0; a0 = 8'h00; a1 = 8'h00; b0 = 8'h00; b1 = 8'h00;
    #1 rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_alu_cntrl", alu_cntrl, 3'b111);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_outputs_zero", {alu_in1, alu_in2, rsp_id, rsp_result, rsp_V, rsp_Z, rsp_cout}, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single ADD 7F+01
    req_valid = 2'b01; op0 = 3'd0; a0 = 8'h7F; b0 = 8'h01; rsp_ready = 1'b1;
    #1 chk("add_req_ready", req_ready, 2'b01);
    tick(1);
    req_valid = 2'b00;
    chk("add_alu_inputs", {alu_cntrl, alu_in1, alu_in2}, {3'd0, 8'h7F, 8'h01});
    chk("add_rv_early", rsp_valid, 1'b0);
    tick(1);
    chk("add_rsp_valid", rsp_valid, 1'b1);
    chk("add_rsp", {rsp_id, rsp_result, rsp_V, rsp_Z, rsp_cout}, {1'b0, 8'h80, 3'b100});
    tick(1);
    chk("add_rsp_consumed", rsp_valid, 1'b0);

    // Round-robin on continuous ties, from a fresh reset
    rst_n = 1'b0; #2 rst_n = 1'b1;
    acc_log.delete(); rsp_log.delete();
    req_valid = 2'b11; op0 = 3'd1; a0 = 8'h05; b0 = 8'h05; op1 = 3'd2; a1 = 8'hF0; b1 = 8'h0F;
    tick(12);
    req_valid = 2'b00;
    chk("rr_accepts", acc_log.size(), 4);
    chk("rr_grant0", acc_at(0), 0);
    chk("rr_grant1", acc_at(1), 1);
    chk("rr_grant2", acc_at(2), 0);
    chk("rr_grant3", acc_at(3), 1);
    chk("rr_rsp0", rsp_at(0), 32'h100);
    chk("rr_rsp1", rsp_at(1), 32'h2FF);

    // Backpressure, with requester 1 waiting throughout
    rsp_ready = 1'b0; req_valid = 2'b01; op0 = 3'd0; a0 = 8'h01; b0 = 8'h02;
    tick(1);
    req_valid = 2'b10;
    tick(1);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_ready", req_ready, 2'b00);
      chk("bp_rsp_hold", {rsp_valid, rsp_id, rsp_result}, {1'b1, 1'b0, 8'h03});
      tick(1);
    end
    rsp_ready = 1'b1;
    tick(1);
    chk("bp_idle", {rsp_valid, req_ready}, {1'b0, 2'b10});
    tick(1);
    chk("bp_next_accept", {alu_cntrl, alu_in1}, {3'd2, 8'hF0});
    req_valid = 2'b00;
    tick(2);

    // Reset during EXEC
    rsp_log.delete();
    req_valid = 2'b01; op0 = 3'd7; a0 = 8'hAA; b0 = 8'h00;
    tick(1);
    req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1 chk("exec_rst", {rsp_valid, alu_cntrl, alu_in1}, {1'b0, 3'b111, 8'h00});
    #1 rst_n = 1'b1;
    tick(4);
    chk("exec_rst_no_rsp", rsp_log.size(), 0);

    // Reset during RESP
    rsp_ready = 1'b0; req_valid = 2'b01; op0 = 3'd7; a0 = 8'hBB;
    tick(1);
    req_valid = 2'b00;
    tick(1);
    chk("resp_pre_rst", {rsp_valid, rsp_result}, {1'b1, 8'hBB});
    #1 rst_n = 1'b0;
    #1 chk("resp_rst", {rsp_valid, rsp_result}, {1'b0, 8'h00});
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    tick(4);
    chk("resp_rst_no_rsp", rsp_log.size(), 0);

    // Requester 1 withdraws while requester 0 holds the ALU
    acc_log.delete(); rsp_log.delete();
    req_valid = 2'b01; op0 = 3'd0; a0 = 8'h10; b0 = 8'h20;
    tick(1);
    req_valid = 2'b10;
    tick(1);
    req_valid = 2'b00;
    tick(4);
    chk("wd_accepts", acc_log.size(), 1);
    chk("wd_accept_id", acc_at(0), 0);
    chk("wd_rsp_count", rsp_log.size(), 1);
    chk("wd_rsp", rsp_at(0), 32'h030);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
